inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port pc_i  in  32  fetch address presented by the PC stage.
REQ-004 SHALL have port pc_read_ready  out  1  PC consumed this cycle; PC stage may advance.
REQ-005 SHALL have ports inst_req out 1 / inst_addr out 32 / inst_addr_ok in 1  address channel to instruction memory.
REQ-006 SHALL have ports inst_data_ok in 1 / inst_rdata in 32  response channel.
REQ-007 SHALL have ports flush in 1 / stall in 1  from CTRL.
REQ-008 SHALL have ports id_valid out 1 / id_pc out 32 / id_inst out 32 / id_excpt_adel out 1  to decode.

Function
REQ-009 SHALL allow at most one outstanding request (address accepted, data not yet returned).
REQ-010 SHALL drive inst_addr = pc_i combinationally.
REQ-011 SHALL assert inst_req when: fetch enabled, pc_i[1:0]==0, no outstanding request, and buffer occupancy < depth.
REQ-012 SHALL assert pc_read_ready = (inst_req & inst_addr_ok) | misaligned-consume (REQ-015).
REQ-013 On inst_req & inst_addr_ok SHALL set outstanding=1 and latch pc_i into req_pc.
REQ-014 On inst_data_ok with outstanding=1 SHALL clear outstanding and push {req_pc, inst_rdata, adel=0}, unless discard=1, in which case SHALL drop data and clear discard.
REQ-015 When pc_i[1:0]!=0, fetch enabled, no outstanding, buffer not full: SHALL issue no memory request, push {pc_i, 32'h0, adel=1}, and assert pc_read_ready for that cycle.
REQ-016 inst_data_ok with outstanding=0 SHALL be ignored.
REQ-017 SHALL drive id_valid = buffer non-empty & !flush; id_pc/id_inst/id_excpt_adel = buffer head.
REQ-018 SHALL pop head on a cycle with id_valid=1 and stall=0; push and pop in the same cycle SHALL both take effect when full.
REQ-019 On flush SHALL empty buffer; if outstanding=1 and inst_data_ok=0 SHALL set discard=1; if inst_data_ok=1 that cycle SHALL drop the data.
REQ-020 During flush SHALL still issue a request for pc_i (new_pc) when REQ-011 holds, excluding outstanding/discard state as of that cycle.
REQ-021 SHALL keep inst_req=0 while discard=1.
REQ-022 stall SHALL NOT block issuing requests; back-pressure acts only through buffer occupancy.

Reset
REQ-023 While rst=0 SHALL hold inst_req=0, pc_read_ready=0, id_valid=0, id_pc=0, id_inst=0, id_excpt_adel=0, outstanding=0, discard=0, buffer empty.
REQ-024 Fetch-enable register SHALL be 0 in reset and set on the first clk edge with rst=1, so the first inst_req occurs in the second cycle after deassertion.
REQ-025 Reset mid-request SHALL abandon the outstanding request; a late inst_data_ok afterwards SHALL be ignored per REQ-016.

Configuration
REQ-026 Macro IF_BUF2_EN defined: buffer depth 2; fetch continues one instruction ahead while decode stalls.
REQ-027 Macro IF_BUF2_EN undefined: buffer depth 1; inst_req blocked while buffer holds an unpopped entry (pop in same cycle does not unblock).

Structure
REQ-028 Constants ZeroWord, InstAddrIncrement, RegBus, InstBus, Valid/Invalid SHALL come from the shared defines file; no local redefinition.
REQ-029 The buffer SHALL be a sub-module fetch_fifo (depth parameter, width 65, push/pop/flush, full/empty).

Verification
REQ-030 Reset release, pc_i=32'hbfc00000, addr_ok=1, data_ok next cycle with 32'h3c08bfc0 -> inst_req first high in cycle 2; id_valid, id_pc=32'hbfc00000, id_inst=32'h3c08bfc0 one cycle after data_ok.
REQ-031 pc_i=32'hbfc00002 -> inst_req=0, pc_read_ready=1 one cycle, id_excpt_adel=1, id_inst=0, id_pc=32'hbfc00002.
REQ-032 flush while request outstanding, new_pc=32'hbfc00380, old data arrives 3 cycles later -> old data never appears on id_*; first id_pc after flush = 32'hbfc00380.
REQ-033 stall held 4 cycles with memory always ready -> with IF_BUF2_EN exactly 2 entries buffered, without exactly 1; no entry lost or duplicated after stall drops.
REQ-034 inst_addr_ok=0 for 5 cycles -> inst_req stays 1, pc_read_ready stays 0, inst_addr stable.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared defines for the instruction fetch slice: bus widths,
//            common constants, the buffered fetch entry and an alignment
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

  localparam int          RegBus            = 32;
  localparam int          InstBus           = 32;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [31:0] InstAddrIncrement = 32'd4;
  localparam logic        Valid             = 1'b1;
  localparam logic        Invalid           = 1'b0;

  // One buffered fetch result: PC, instruction word, address-error flag
  localparam int FIFO_W = RegBus + InstBus + 1;

  typedef struct packed {
    logic [RegBus-1:0]  pc;
    logic [InstBus-1:0] inst;
    logic               adel;
  } fetch_entry_t;

  // A fetch address is legal only on an instruction-size boundary
  function automatic logic is_aligned(input logic [RegBus-1:0] addr);
    return (addr & (InstAddrIncrement - 32'd1)) == ZeroWord;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_if
// Purpose  : Instruction memory request/response channel. The fetch stage
//            is the master; the instruction memory is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic               inst_req;
  logic [RegBus-1:0]  inst_addr;
  logic               inst_addr_ok;
  logic               inst_data_ok;
  logic [InstBus-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO holding fetched entries between the
//            memory response and decode. Flush empties it but still accepts
//            a push presented in the same cycle. Push and pop in one cycle
//            both take effect, also when full.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 65
) (
  input  wire  logic             clk,
  input  wire  logic             rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int                 PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 SLOTS     = 1 << PTR_W;
  localparam int                 CNT_W     = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]   FIRST_PTR = '0;
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   ONE_CNT   = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [SLOTS];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? FIRST_PTR : p + 1'b1;
  endfunction

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
      r_wr_ptr <= FIRST_PTR;
      r_rd_ptr <= FIRST_PTR;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= FIRST_PTR;
      if (i_push) begin
        r_mem[FIRST_PTR] <= i_data;
        r_wr_ptr         <= ptr_inc(FIRST_PTR);
        r_count          <= ONE_CNT;
      end else begin
        r_wr_ptr <= FIRST_PTR;
        r_count  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage. Issues one memory request at a time
//            for pc_i, turns misaligned PCs into address-error entries
//            without touching memory, buffers results for decode and
//            discards a response that belongs to a flushed request.
// Config   : IF_BUF2_EN defined   -> two-entry buffer (fetch runs one ahead)
//            IF_BUF2_EN undefined -> one-entry buffer
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  wire  logic              clk,
  input  wire  logic              rst,
  input  logic [RegBus-1:0]       pc_i,
  output logic                    pc_read_ready,
  inst_fetch_if.master            mem,
  input  logic                    flush,
  input  logic                    stall,
  output logic                    id_valid,
  output logic [RegBus-1:0]       id_pc,
  output logic [InstBus-1:0]      id_inst,
  output logic                    id_excpt_adel
);

`ifdef IF_BUF2_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  logic              r_fetch_en;
  logic              r_outstanding;
  logic              r_discard;
  logic [RegBus-1:0] r_req_pc;

  logic              w_aligned;
  logic              w_can_fetch;
  logic              w_adel;
  logic              w_addr_hs;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // Request eligibility: only the registered state gates issue, so a flush
  // cycle can already issue for the redirected PC when nothing is in flight.
  assign w_aligned     = is_aligned(pc_i);
  assign w_can_fetch   = r_fetch_en & ~r_outstanding & ~r_discard & ~w_full;
  assign mem.inst_req  = w_can_fetch & w_aligned;
  assign mem.inst_addr = pc_i;
  assign w_adel        = w_can_fetch & ~w_aligned;
  assign w_addr_hs     = mem.inst_req & mem.inst_addr_ok;
  assign pc_read_ready = w_addr_hs | w_adel;

  // Responses only count against an open request; stale or flushed data drops
  assign w_resp        = r_outstanding & mem.inst_data_ok;
  assign w_push        = (w_resp & ~r_discard & ~flush) | w_adel;
  assign w_push_entry  = w_adel ? '{pc: pc_i,     inst: ZeroWord,       adel: Valid}
                                : '{pc: r_req_pc, inst: mem.inst_rdata, adel: Invalid};

  assign id_valid      = ~w_empty & ~flush;
  assign w_pop         = id_valid & ~stall;
  assign id_pc         = w_head.pc;
  assign id_inst       = w_head.inst;
  assign id_excpt_adel = w_head.adel;

  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Fetch enable, in-flight request tracking and discard of flushed responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_en    <= Invalid;
      r_outstanding <= Invalid;
      r_discard     <= Invalid;
      r_req_pc      <= ZeroWord;
    end else begin
      r_fetch_en <= Valid;
      if (w_addr_hs) begin
        r_outstanding <= Valid;
        r_req_pc      <= pc_i;
      end else if (w_resp) begin
        r_outstanding <= Invalid;
      end
      if (w_resp)
        r_discard <= Invalid;
      else if (flush && r_outstanding)
        r_discard <= Valid;
    end
  end

endmodule
`default_nettype wire
